// File: rtl/cipher_pkg.sv
// Shared types and widths for the cipher job scheduler.
package cipher_pkg;
    localparam int DATA_W = 128;
    localparam int ADDR_W = 8;
    localparam int TMR_W  = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_RELEASE,
        S_RESP
    } state_t;

    function automatic logic [TMR_W-1:0] tmr_inc(input logic [TMR_W-1:0] t);
        return (&t) ? t : t + 1'b1;
    endfunction
endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; priority moves away from the last winner.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);
    logic prio; // requester favoured when both ask

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = prio ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio <= 1'b0;
        end else if (update && (|grant)) begin
            prio <= ~grant[1];
        end
    end
endmodule

// File: rtl/cipher_sched.sv
// Schedules cipher jobs from two requesters onto one start/busy datapath.
module cipher_sched
    import cipher_pkg::*;
#(
    parameter int BUSY_TMO = 8,
    parameter int RUN_TMO  = 63
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [DATA_W-1:0] req_block0,
    input  logic [DATA_W-1:0] req_block1,
    input  logic [DATA_W-1:0] req_key0,
    input  logic [DATA_W-1:0] req_key1,
    input  logic [1:0]        req_ende,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              dp_start,
    output logic              dp_ende,
    output logic [DATA_W-1:0] dp_block,
    output logic [DATA_W-1:0] dp_key,
    output logic [ADDR_W-1:0] dp_addr,
    input  logic              dp_busy,
    input  logic [DATA_W-1:0] dp_o,
    output state_t            fsm_state
);
    // Handshakes: a request transfers on the cycle req_ready[i] pulses (IDLE only);
    // a result transfers when rsp_valid && rsp_ready, and rsp_* hold until then.
    localparam logic [TMR_W-1:0] BUSY_LIM = TMR_W'(BUSY_TMO - 1);
    localparam logic [TMR_W-1:0] RUN_LIM  = TMR_W'(RUN_TMO - 1);

    state_t            state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [1:0]        grant;
    logic              arb_update, load_job, set_ok, set_err, addr_inc;
    logic              job_id, job_ende;
    logic [DATA_W-1:0] job_block, job_key;

    rr_arb2 u_arb (
        .clk    (Clk),
        .reset  (Reset),
        .req    (req_valid),
        .update (arb_update),
        .grant  (grant)
    );

    always_comb begin
        state_d    = state_q;
        timer_d    = tmr_inc(timer_q);
        arb_update = 1'b0;
        load_job   = 1'b0;
        set_ok     = 1'b0;
        set_err    = 1'b0;
        addr_inc   = 1'b0;
        req_ready  = 2'b00;
        dp_start   = 1'b0;
        rsp_valid  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|grant) begin
                    req_ready  = grant;
                    arb_update = 1'b1;
                    load_job   = 1'b1;
                    state_d    = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                dp_start = 1'b1;
                state_d  = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                dp_start = 1'b1;
                if (dp_busy) begin
                    state_d = S_RELEASE;
                end else if (timer_q == BUSY_LIM) begin
                    set_err = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RELEASE: begin
                if (!dp_busy) begin
                    set_ok  = 1'b1;
                    state_d = S_RESP;
                end else if (timer_q == RUN_LIM) begin
                    set_err = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    addr_inc = ~rsp_err;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Every state entry restarts the timeout count.
        if (state_d != state_q) begin
            timer_d = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            job_id    <= 1'b0;
            job_ende  <= 1'b0;
            job_block <= '0;
            job_key   <= '0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            dp_addr   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            if (load_job) begin
                job_id    <= grant[1];
                job_ende  <= req_ende[grant[1]];
                job_block <= grant[1] ? req_block1 : req_block0;
                job_key   <= grant[1] ? req_key1 : req_key0;
            end
            if (set_ok) begin
                rsp_id   <= job_id;
                rsp_data <= dp_o;
                rsp_err  <= 1'b0;
            end
            if (set_err) begin
                rsp_id   <= job_id;
                rsp_data <= '0;
                rsp_err  <= 1'b1;
            end
            if (addr_inc) begin
                dp_addr <= dp_addr + 1'b1;
            end
        end
    end

    assign dp_ende   = job_ende;
    assign dp_block  = job_block;
    assign dp_key    = job_key;
    assign fsm_state = state_q;
endmodule

// File: tb/tb_cipher_sched.sv
// Randomised bench for cipher_sched with a datapath stub and a transaction-level model.
module tb_cipher_sched;
    import cipher_pkg::*;

    localparam logic [127:0] C_ENC = 128'h9F589F5CF6122C32B6BFEC2F2AE8C35A;
    localparam logic [127:0] C_DEC = 128'h0123456789ABCDEFFEDCBA9876543210;

    logic         Clk = 1'b0;
    logic         Reset = 1'b1;
    logic [1:0]   req_valid = 2'b00;
    logic [1:0]   req_ready;
    logic [127:0] req_block0 = '0, req_block1 = '0, req_key0 = '0, req_key1 = '0;
    logic [1:0]   req_ende = 2'b00;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [127:0] rsp_data;
    logic         dp_start, dp_ende, dp_busy;
    logic [127:0] dp_block, dp_key, dp_o;
    logic [7:0]   dp_addr;
    state_t       fsm_state;

    cipher_sched dut (
        .Clk(Clk), .Reset(Reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_block0(req_block0), .req_block1(req_block1), .req_key0(req_key0), .req_key1(req_key1),
        .req_ende(req_ende), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .dp_start(dp_start), .dp_ende(dp_ende),
        .dp_block(dp_block), .dp_key(dp_key), .dp_addr(dp_addr), .dp_busy(dp_busy),
        .dp_o(dp_o), .fsm_state(fsm_state)
    );

    always #5 Clk = ~Clk;

    // Datapath function the stub computes; zero block/key/encrypt yields C_ENC.
    function automatic logic [127:0] dp_model(input logic [127:0] b, input logic [127:0] k, input logic e);
        return b ^ {k[63:0], k[127:64]} ^ (e ? C_DEC : C_ENC);
    endfunction

    // Datapath stub: busy rises stub_delay cycles after start is seen, stays up stub_len cycles.
    int           stub_delay = 1, stub_len = 1;
    bit           stub_never = 1'b0;
    int           st_state, st_cnt;
    logic [127:0] st_b, st_k;
    logic         st_e;

    always @(posedge Clk) begin
        if (Reset) begin
            st_state <= 0;
            st_cnt   <= 0;
            dp_busy  <= 1'b0;
            dp_o     <= '0;
        end else begin
            case (st_state)
                0: if (dp_start && !stub_never) begin
                    st_b <= dp_block;
                    st_k <= dp_key;
                    st_e <= dp_ende;
                    if (stub_delay == 0) begin
                        dp_busy  <= 1'b1;
                        st_cnt   <= stub_len;
                        st_state <= 2;
                    end else begin
                        st_cnt   <= stub_delay;
                        st_state <= 1;
                    end
                end
                1: if (st_cnt == 1) begin
                    dp_busy  <= 1'b1;
                    st_cnt   <= stub_len;
                    st_state <= 2;
                end else begin
                    st_cnt <= st_cnt - 1;
                end
                default: if (st_cnt == 1) begin
                    dp_busy  <= 1'b0;
                    dp_o     <= dp_model(st_b, st_k, st_e);
                    st_state <= 0;
                end else begin
                    st_cnt <= st_cnt - 1;
                end
            endcase
        end
    end

    // Response readiness: 0 random, 1 always ready, 2 never ready.
    int rdy_mode = 1;
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge Clk);
            #1;
            case (rdy_mode)
                0:       rsp_ready = ($urandom_range(0, 3) != 0);
                1:       rsp_ready = 1'b1;
                default: rsp_ready = 1'b0;
            endcase
        end
    end

    typedef struct packed {
        logic         id;
        logic         err;
        logic [127:0] data;
    } rsp_t;

    rsp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   last_grant = -1;
    int   addr_model = 0;
    bit   job_live = 1'b0;
    bit   cmp_en = 1'b0;
    logic [127:0] cur_b, cur_k;
    logic         cur_e;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: predicts grants, job contents and responses from the arbitration rules.
    logic [1:0] want;
    rsp_t       r;
    always @(negedge Clk) begin
        if (Reset) begin
            exp_q.delete();
            job_live   = 1'b0;
            last_grant = -1;
            addr_model = 0;
        end else if (cmp_en) begin
            want = 2'b00;
            if (!job_live) begin
                if (req_valid == 2'b11) want = (last_grant == 0) ? 2'b10 : 2'b01;
                else                    want = req_valid;
            end
            check("req_ready", 128'(req_ready), 128'(want));
            check("dp_addr", 128'(dp_addr), 128'(addr_model));
            if (!job_live) check("dp_start_idle", 128'(dp_start), 128'(0));
            if (job_live && dp_start) begin
                check("dp_block", dp_block, cur_b);
                check("dp_key", dp_key, cur_k);
                check("dp_ende", 128'(dp_ende), 128'(cur_e));
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 128'(rsp_valid), 128'(0));
                end else begin
                    r = exp_q[0];
                    check("rsp_id", 128'(rsp_id), 128'(r.id));
                    check("rsp_err", 128'(rsp_err), 128'(r.err));
                    check("rsp_data", rsp_data, r.data);
                    if (rsp_ready) begin
                        void'(exp_q.pop_front());
                        if (!r.err) addr_model = (addr_model + 1) % 256;
                        job_live = 1'b0;
                    end
                end
            end
            if (want != 2'b00) begin
                last_grant = want[1] ? 1 : 0;
                cur_b      = want[1] ? req_block1 : req_block0;
                cur_k      = want[1] ? req_key1 : req_key0;
                cur_e      = req_ende[want[1]];
                r.id       = want[1];
                r.err      = stub_never || (stub_delay > 7) || (stub_len > 63);
                r.data     = r.err ? '0 : dp_model(cur_b, cur_k, cur_e);
                exp_q.push_back(r);
                job_live   = 1'b1;
            end
        end
    end

    task automatic do_reset();
        @(posedge Clk);
        #1;
        Reset     = 1'b1;
        req_valid = 2'b00;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
    endtask

    task automatic wait_accept(input int budget, output logic [1:0] g);
        int n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (req_ready == 2'b00 && n < budget);
        g = req_ready;
        checks++;
        if (req_ready == 2'b00) begin
            errors++;
            $display("FAIL accept_timeout: got no grant after %0d cycles", n);
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_rsp(input int budget, output int lat);
        int n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (!rsp_valid && n < budget);
        lat = n - 1;
        checks++;
        if (!rsp_valid) begin
            errors++;
            $display("FAIL rsp_timeout: got no rsp_valid after %0d cycles", n);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((job_live || exp_q.size() != 0 || st_state != 0 || dp_busy) && n < budget) begin
            @(posedge Clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL idle_timeout: still busy after %0d cycles", n);
        end
    endtask

    task automatic load_reqs();
        req_block0 = {$urandom, $urandom, $urandom, $urandom};
        req_block1 = {$urandom, $urandom, $urandom, $urandom};
        req_key0   = {$urandom, $urandom, $urandom, $urandom};
        req_key1   = {$urandom, $urandom, $urandom, $urandom};
        req_ende   = 2'($urandom_range(0, 3));
    endtask

    task automatic do_job(input logic [1:0] v, input int d, input int l, input bit never);
        logic [1:0] g;
        @(posedge Clk);
        #1;
        stub_delay = d;
        stub_len   = l;
        stub_never = never;
        load_reqs();
        req_valid = v;
        wait_accept(50, g);
        req_valid = 2'b00;
        wait_idle(400);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] g;
        logic [1:0] gl[4];
        int lat;
        int addr0;

        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b0;
        cmp_en = 1'b1;
        @(negedge Clk);
        check("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        check("rst_dp_start", 128'(dp_start), 128'(0));
        check("rst_rsp_id", 128'(rsp_id), 128'(0));
        check("rst_rsp_err", 128'(rsp_err), 128'(0));
        check("rst_rsp_data", rsp_data, 128'(0));
        check("rst_dp_addr", 128'(dp_addr), 128'(0));

        // Zero key/block encrypt on requester 0.
        @(posedge Clk);
        #1;
        rdy_mode = 1; stub_delay = 2; stub_len = 5; stub_never = 1'b0;
        req_block0 = '0; req_key0 = '0; req_ende = 2'b00;
        req_valid = 2'b01;
        wait_accept(20, g);
        req_valid = 2'b00;
        check("first_grant", 128'(g), 128'(2'b01));
        wait_rsp(100, lat);
        check("first_data", rsp_data, C_ENC);
        check("first_id", 128'(rsp_id), 128'(0));
        check("first_latency", 128'(lat), 128'(9));
        wait_idle(100);
        @(negedge Clk);
        check("first_addr", 128'(dp_addr), 128'(1));

        // Random traffic with random backpressure.
        rdy_mode = 0;
        for (int i = 0; i < 30; i++) begin
            do_job(2'($urandom_range(1, 3)), $urandom_range(0, 7), $urandom_range(1, 30), 1'b0);
        end

        // Timeout boundaries: last in-window cycle succeeds, one later fails.
        rdy_mode = 1;
        do_job(2'b01, 7, 3, 1'b0);
        do_job(2'b10, 8, 3, 1'b0);
        do_job(2'b01, 1, 63, 1'b0);
        do_job(2'b10, 1, 64, 1'b0);

        // Busy never rises.
        @(negedge Clk);
        addr0 = int'(dp_addr);
        @(posedge Clk);
        #1;
        stub_never = 1'b1;
        load_reqs();
        req_valid = 2'b10;
        wait_accept(20, g);
        req_valid = 2'b00;
        wait_rsp(100, lat);
        check("tmo_err", 128'(rsp_err), 128'(1));
        check("tmo_data", rsp_data, 128'(0));
        check("tmo_latency", 128'(lat), 128'(9));
        wait_idle(100);
        @(negedge Clk);
        check("tmo_addr", 128'(dp_addr), 128'(addr0));
        stub_never = 1'b0;

        // Both requesting continuously after reset alternates from requester 0.
        do_reset();
        stub_delay = 1; stub_len = 3;
        load_reqs();
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            wait_accept(100, g);
            gl[i] = g;
        end
        req_valid = 2'b00;
        wait_idle(200);
        check("rr_g0", 128'(gl[0]), 128'(2'b01));
        check("rr_g1", 128'(gl[1]), 128'(2'b10));
        check("rr_g2", 128'(gl[2]), 128'(2'b01));
        check("rr_g3", 128'(gl[3]), 128'(2'b10));

        // Consumer stalls: response held, no new grant.
        rdy_mode = 2;
        @(posedge Clk);
        #1;
        load_reqs();
        req_valid = 2'b01;
        wait_accept(20, g);
        req_valid = 2'b00;
        wait_rsp(100, lat);
        @(posedge Clk);
        #1;
        req_valid = 2'b11;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            check("stall_valid", 128'(rsp_valid), 128'(1));
            check("stall_no_grant", 128'(req_ready), 128'(0));
        end
        @(posedge Clk);
        #1;
        req_valid = 2'b00;
        rdy_mode = 1;
        wait_idle(100);

        // Address wrap.
        do_reset();
        for (int i = 0; i < 255; i++) begin
            do_job(2'($urandom_range(1, 3)), 0, 1, 1'b0);
        end
        @(negedge Clk);
        check("addr_255", 128'(dp_addr), 128'(255));
        do_job(2'b10, 2, 4, 1'b0);
        @(negedge Clk);
        check("addr_wrap", 128'(dp_addr), 128'(0));

        // Reset while the datapath is running.
        @(posedge Clk);
        #1;
        stub_delay = 1; stub_len = 20;
        load_reqs();
        req_valid = 2'b01;
        wait_accept(20, g);
        req_valid = 2'b00;
        repeat (6) @(posedge Clk);
        check("mid_busy", 128'(dp_busy), 128'(1));
        do_reset();
        @(negedge Clk);
        check("mid_rsp_valid", 128'(rsp_valid), 128'(0));
        check("mid_dp_start", 128'(dp_start), 128'(0));
        check("mid_req_ready", 128'(req_ready), 128'(0));
        repeat (40) @(posedge Clk);

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
